disp_beep_ctrl: RTL and testbench
=================================

// Module: disp_beep_ctrl
// PURPOSE
//   Parametrised display and buzzer front end for the lab board.
//   Drives N_DIG digits with per-digit flicker: digit 0 through an on-chip 7-segment decoder,
//   digits 1..N_DIG-1 as raw BCD.
//   Generates the buzzer waveform from a counted-beep sequencer, a continuous tone and a blink-synced alarm.
//   Sits between the control FSM (digit values, masks, beep requests) and the board pins; all timing is derived from one clock.
// PARAMETERS
//   N_DIG       6    number of digits (>=2)
//   BLINK_HALF  125  clock ticks per blink half-period (125 @1kHz = 4Hz blink)
//   BEEP_ON     200  ticks per beep tone window
//   BEEP_OFF    200  ticks of silence between beeps
// PORTS
//   clk_1khz      in   1            system clock, 1kHz
//   clr           in   1            asynchronous, active-high reset
//   digits        in   4*N_DIG      digit i value at [4i+3:4i]
//   flicker_mask  in   N_DIG        1 = digit i blinks
//   hold_on       in   1            continuous tone while high
//   alarm_on      in   1            tone gated by blink_phase while high
//   beep_start    in   1            single-cycle request for a counted sequence
//   beep_n        in   4            number of beeps, sampled with beep_start
//   seg_out       out  7            digit 0 segments, {g,f,e,d,c,b,a}, active-high
//   bcd_out       out  4*(N_DIG-1) digits 1..N_DIG-1; field j-1 = digit j
//   beep          out  1            buzzer drive
//   beep_busy     out  1            counted sequence in progress
//   blink_phase   out  1            1 = flickering digits visible
// BEHAVIOUR
//   Reset: all outputs and state reset asynchronously on clr.
//     seg_out=0, bcd_out=all 4'hF (blank), beep=0, beep_busy=0.
//     blink_phase=1, blink counter=0, sequencer=IDLE, tone=0.
//   Blink counter: counts 0..BLINK_HALF-1.
//     On wrap it returns to 0 and blink_phase toggles, giving a period of 2*BLINK_HALF ticks.
//   Display: seg_out and bcd_out are registered (1-cycle latency from digits, flicker_mask and blink_phase).
//     Digit i is shown if !flicker_mask[i] || blink_phase.
//     Otherwise it is blanked: seg_out=0 or BCD field=4'hF.
//     Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); values A-F decode to 0.
//     BCD fields pass through unchanged, including values >9.
//   Sequencer FSM: states IDLE, ON, OFF; a 4-bit remaining-beep counter (rem) and a tick timer.
//     IDLE: beep_start && beep_n!=0 -> ON; rem<=beep_n; timer<=0.
//       beep_start with beep_n==0 is ignored.
//     ON: timer counts to BEEP_ON-1, then timer<=0.
//       If rem==1 -> IDLE; else rem<=rem-1 and -> OFF.
//     OFF: timer counts to BEEP_OFF-1, then timer<=0 and -> ON.
//     beep_start while not IDLE is ignored: no retrigger, rem unchanged.
//     beep_busy is registered and equals (state!=IDLE) one cycle after the state changes.
//   Tone: a 1-bit register toggles every cycle, giving a 500Hz square wave.
//   Envelope and output:
//     env = hold_on | (state==ON) | (alarm_on & blink_phase).
//     beep <= env & tone (registered), so beep is 0 whenever env is 0.
//     Sources that are active at the same time are OR-merged with no priority and no extension of the sequence.
//   clr mid-sequence: beep and beep_busy drop to 0 immediately.
//     The sequencer returns to IDLE and a new beep_start is accepted in the first cycle after clr deasserts.
// TESTING
//   1. clr, then digits=24'h654321, mask=0
//      -> after 1 clk: seg_out=7'h06, bcd_out=20'h65432, steady.
//   2. mask=6'b000010
//      -> bcd_out[3:0] alternates 2 / F every 125 clks; all other fields and seg_out stay constant.
//   3. beep_start, beep_n=3
//      -> beep_busy high for 3*200+2*200=1000 clks.
//      -> beep toggles in three 200-clk windows and is 0 in the two gaps.
//   4. beep_n=0 start -> no activity. A start at clk 50 of a running 2-beep sequence
//      -> total still 2 beeps, busy length 600.
//   5. clr pulse during the 2nd ON window -> beep=0 and busy=0 at once.
//      After release a new beep_n=1 start gives 200 clks of busy.
//   6. alarm_on=1 with hold_on=0 -> beep toggles only while blink_phase=1 (125 on / 125 off).
//      Adding hold_on=1 -> beep toggles continuously.

Source files
------------

// File: rtl/disp_beep_if.sv
// Bundles the display/buzzer front-end signals between the control FSM (master)
// and disp_beep_ctrl (slave).
interface disp_beep_if #(
  parameter int N_DIG = 6
);
  logic [4*N_DIG-1:0]     digits;
  logic [N_DIG-1:0]       flicker_mask;
  logic                   hold_on;
  logic                   alarm_on;
  logic                   beep_start;
  logic [3:0]             beep_n;
  logic [6:0]             seg_out;
  logic [4*(N_DIG-1)-1:0] bcd_out;
  logic                   beep;
  logic                   beep_busy;
  logic                   blink_phase;

  modport master (
    output digits, flicker_mask, hold_on, alarm_on, beep_start, beep_n,
    input  seg_out, bcd_out, beep, beep_busy, blink_phase
  );

  modport slave (
    input  digits, flicker_mask, hold_on, alarm_on, beep_start, beep_n,
    output seg_out, bcd_out, beep, beep_busy, blink_phase
  );
endinterface

// File: rtl/disp_beep_ctrl.sv
// Display and buzzer front end: blinking 7-segment/BCD digit outputs plus a buzzer
// driven by a counted-beep sequencer, a continuous tone and a blink-synced alarm.
module disp_beep_ctrl #(
  parameter int N_DIG      = 6,
  parameter int BLINK_HALF = 125,
  parameter int BEEP_ON    = 200,
  parameter int BEEP_OFF   = 200
) (
  input logic         clk_1khz,
  input logic         clr,
  disp_beep_if.slave  bus
);

  localparam int BW     = $clog2(BLINK_HALF + 1);
  localparam int T_MAX  = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int BCD_W  = 4 * (N_DIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [BW-1:0]    blink_cnt_r;
  logic             blink_phase_r;
  logic [6:0]       seg_r;
  logic [BCD_W-1:0] bcd_r;
  logic [6:0]       seg_next_s;
  logic [BCD_W-1:0] bcd_next_s;
  state_t           state_r;
  logic [3:0]       rem_r;
  logic [TW-1:0]    timer_r;
  logic             busy_r;
  logic             tone_r;
  logic             beep_r;
  logic             env_s;

  // Blink timebase: phase flips every BLINK_HALF ticks.
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else if (blink_cnt_r == BW'(BLINK_HALF - 1)) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BW'(1);
    end
  end

  // Next display image: hidden flickering digits blank to 0 segments / BCD 4'hF.
  always_comb begin
    bcd_next_s = '1;
    if (!bus.flicker_mask[0] || blink_phase_r) begin
      seg_next_s = seg_decode(bus.digits[3:0]);
    end else begin
      seg_next_s = 7'h00;
    end
    for (int j = 1; j < N_DIG; j++) begin
      if (!bus.flicker_mask[j] || blink_phase_r) begin
        bcd_next_s[4*(j-1) +: 4] = bus.digits[4*j +: 4];
      end else begin
        bcd_next_s[4*(j-1) +: 4] = 4'hF;
      end
    end
  end

  // Display output registers.
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      seg_r <= 7'h00;
      bcd_r <= '1;
    end else begin
      seg_r <= seg_next_s;
      bcd_r <= bcd_next_s;
    end
  end

  // Counted-beep sequencer; starts are only honoured from IDLE.
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      rem_r   <= 4'd0;
      timer_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.beep_start && (bus.beep_n != 4'd0)) begin
            state_r <= ST_ON;
            rem_r   <= bus.beep_n;
            timer_r <= '0;
          end
        end
        ST_ON: begin
          if (timer_r == TW'(BEEP_ON - 1)) begin
            timer_r <= '0;
            if (rem_r == 4'd1) begin
              state_r <= ST_IDLE;
            end else begin
              rem_r   <= rem_r - 4'd1;
              state_r <= ST_OFF;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_OFF: begin
          if (timer_r == TW'(BEEP_OFF - 1)) begin
            timer_r <= '0;
            state_r <= ST_ON;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rem_r   <= 4'd0;
          timer_r <= '0;
        end
      endcase
    end
  end

  // Buzzer envelope: all sources OR-merged without priority.
  always_comb begin
    env_s = bus.hold_on | (state_r == ST_ON) | (bus.alarm_on & blink_phase_r);
  end

  // Square-wave carrier and gated buzzer output.
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      tone_r <= 1'b0;
      beep_r <= 1'b0;
    end else begin
      tone_r <= ~tone_r;
      beep_r <= env_s & tone_r;
    end
  end

  assign bus.seg_out     = seg_r;
  assign bus.bcd_out     = bcd_r;
  assign bus.beep        = beep_r;
  assign bus.beep_busy   = busy_r;
  assign bus.blink_phase = blink_phase_r;

endmodule

// File: tb/tb_disp_beep_ctrl.sv
// Randomised and directed bench for disp_beep_ctrl, checked every cycle against a
// timeline model (outputs derived from cycle count since reset and start time).
module tb_disp_beep_ctrl;
  localparam int N_DIG      = 6;
  localparam int BLINK_HALF = 125;
  localparam int BEEP_ON    = 200;
  localparam int BEEP_OFF   = 200;
  localparam int PER        = BEEP_ON + BEEP_OFF;

  logic clk_1khz;
  logic clr;

  disp_beep_if #(.N_DIG(N_DIG)) bus ();

  disp_beep_ctrl #(
    .N_DIG(N_DIG), .BLINK_HALF(BLINK_HALF), .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF)
  ) dut (
    .clk_1khz(clk_1khz),
    .clr(clr),
    .bus(bus)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  int n_vec  = 0;
  int n_fail = 0;

  // Timeline model: k = edges since clr released; sequence started at edge s with sn beeps.
  int k  = 0;
  int s  = 0;
  int sn = 0;
  bit sv = 1'b0;
  int cnt_busy = 0;
  int cnt_beep = 0;
  logic [6:0] dec_tab [16];

  function automatic bit phase_at(input int kk);
    return ((kk / BLINK_HALF) % 2) == 0;
  endfunction

  function automatic bit busy_at(input int kk);
    return sv && ((kk - s) < (sn * PER - BEEP_OFF));
  endfunction

  function automatic bit on_at(input int kk);
    return busy_at(kk) && (((kk - s) % PER) < BEEP_ON);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
    end
  endtask

  task automatic step();
    logic [6:0]  e_seg;
    logic [19:0] e_bcd;
    bit          ph;
    bit          e_busy;
    bit          e_beep;
    bit          e_phase;
    ph = phase_at(k);
    e_seg = (bus.flicker_mask[0] && !ph) ? 7'h00 : dec_tab[bus.digits[3:0]];
    for (int j = 1; j < N_DIG; j++) begin
      e_bcd[4*(j-1) +: 4] = (bus.flicker_mask[j] && !ph) ? 4'hF : bus.digits[4*j +: 4];
    end
    e_busy  = busy_at(k);
    e_beep  = (bus.hold_on | on_at(k) | (bus.alarm_on & ph)) & (k % 2 == 1);
    e_phase = phase_at(k + 1);
    if (bus.beep_start && (bus.beep_n != 4'd0) && !busy_at(k)) begin
      sv = 1'b1;
      s  = k + 1;
      sn = int'(bus.beep_n);
    end
    k++;
    @(posedge clk_1khz);
    #1;
    check("seg_out",     32'(bus.seg_out),     32'(e_seg));
    check("bcd_out",     32'(bus.bcd_out),     32'(e_bcd));
    check("beep_busy",   32'(bus.beep_busy),   32'(e_busy));
    check("beep",        32'(bus.beep),        32'(e_beep));
    check("blink_phase", 32'(bus.blink_phase), 32'(e_phase));
    cnt_busy += int'(bus.beep_busy);
    cnt_beep += int'(bus.beep);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},   32'(bus.seg_out),     32'h0);
    check({tag, "_bcd"},   32'(bus.bcd_out),     32'hFFFFF);
    check({tag, "_beep"},  32'(bus.beep),        32'h0);
    check({tag, "_busy"},  32'(bus.beep_busy),   32'h0);
    check({tag, "_phase"}, 32'(bus.blink_phase), 32'h1);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    #1;
    check_reset_outputs("clr");
    #1;
    clr = 1'b0;
    k  = 0;
    sv = 1'b0;
  endtask

  task automatic start_beeps(input logic [3:0] n);
    bus.beep_start = 1'b1;
    bus.beep_n     = n;
    step();
    bus.beep_start = 1'b0;
  endtask

  initial begin
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    clr              = 1'b1;
    bus.digits       = 24'h654321;
    bus.flicker_mask = 6'b000000;
    bus.hold_on      = 1'b0;
    bus.alarm_on     = 1'b0;
    bus.beep_start   = 1'b0;
    bus.beep_n       = 4'd0;
    #2;
    check_reset_outputs("reset");
    #1;
    clr = 1'b0;

    // Static digits, no blinking.
    step();
    check("t1_seg_lit", 32'(bus.seg_out), 32'h06);
    check("t1_bcd_lit", 32'(bus.bcd_out), 32'h65432);
    run(20);

    // Digit 1 flickers.
    bus.flicker_mask = 6'b000010;
    run(300);
    bus.flicker_mask = 6'b000000;

    // Three-beep sequence.
    cnt_busy = 0; cnt_beep = 0;
    start_beeps(4'd3);
    run(1100);
    check("t3_busy_len",  32'(cnt_busy), 32'd1000);
    check("t3_beep_high", 32'(cnt_beep), 32'd300);

    // Zero-count start is ignored.
    cnt_busy = 0; cnt_beep = 0;
    start_beeps(4'd0);
    run(50);
    check("t4_zero_busy", 32'(cnt_busy), 32'd0);

    // Retrigger during a running sequence is ignored.
    cnt_busy = 0; cnt_beep = 0;
    start_beeps(4'd2);
    run(49);
    start_beeps(4'd5);
    run(700);
    check("t4_busy_len",  32'(cnt_busy), 32'd600);
    check("t4_beep_high", 32'(cnt_beep), 32'd200);

    // Reset in the second ON window, then a fresh single beep.
    start_beeps(4'd3);
    run(450);
    clr_pulse();
    cnt_busy = 0; cnt_beep = 0;
    start_beeps(4'd1);
    run(300);
    check("t5_busy_len", 32'(cnt_busy), 32'd200);

    // Alarm gated by blink phase, then continuous hold tone.
    bus.alarm_on = 1'b1;
    run(37);
    cnt_beep = 0;
    run(1000);
    check("t6_alarm_high", 32'(cnt_beep), 32'd248);
    bus.hold_on = 1'b1;
    cnt_beep = 0;
    run(1000);
    check("t6_hold_high", 32'(cnt_beep), 32'd500);
    bus.hold_on  = 1'b0;
    bus.alarm_on = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.digits       = 24'($urandom());
      bus.flicker_mask = 6'($urandom());
      bus.hold_on      = ($urandom_range(0, 19) == 0);
      bus.alarm_on     = ($urandom_range(0, 9) == 0);
      bus.beep_start   = ($urandom_range(0, 29) == 0);
      bus.beep_n       = 4'($urandom_range(0, 3));
      step();
      if ($urandom_range(0, 999) == 0) clr_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
